// File: rtl/int_ctrl_if.sv
// Interrupt sequencer bus: IF/EX state in, PC redirect and hold requests out.
// master is the core side, slave is int_ctrl.
interface int_ctrl_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_en;
    logic [ADDR_W-1:0]  inst_addr;
    logic               hold_pc;
    logic               ex_jump_flag;
    logic [ADDR_W-1:0]  ex_jump_pc;
    logic               reti;

    logic               int_jump_flag;
    logic [ADDR_W-1:0]  int_jump_pc;
    logic [1:0]         int_hold_flag;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [ADDR_W-1:0]  epc;
    logic               int_active;

    modport master (
        output irq, irq_en, inst_addr, hold_pc, ex_jump_flag, ex_jump_pc, reti,
        input  int_jump_flag, int_jump_pc, int_hold_flag, irq_ack, epc, int_active
    );

    modport slave (
        input  irq, irq_en, inst_addr, hold_pc, ex_jump_flag, ex_jump_pc, reti,
        output int_jump_flag, int_jump_pc, int_hold_flag, irq_ack, epc, int_active
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt sequencer: freezes fetch, drains the pipeline, saves the return PC,
// redirects to the selected vector and restores the PC on return-from-interrupt.
module int_ctrl #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       NUM_IRQ      = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE     = 16'h0040,
    parameter logic [ADDR_W-1:0] VEC_STRIDE   = 16'h0004,
    parameter int unsigned       DRAIN_CYCLES = 3
) (
    input logic       clk,
    input logic       rst_n,
    int_ctrl_if.slave bus
);

    localparam int unsigned IdW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [1:0]  HoldNone = 2'b00;
    localparam logic [1:0]  HoldPc   = 2'b01;
    localparam logic [1:0]  HoldPpl  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StJump,
        StService,
        StReturn
    } state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;

    logic [NUM_IRQ-1:0] pending;
    logic [IdW-1:0]     sel_id;
    logic               accept;
    logic [ADDR_W-1:0]  vec_addr;

    logic               jump_flag;
    logic [ADDR_W-1:0]  jump_pc;
    logic [1:0]         hold_flag;
    logic [NUM_IRQ-1:0] ack;
    logic               active;

    assign pending = bus.irq & bus.irq_en;

    // Scan downwards so the lowest pending index wins.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = IdW'(i);
            end
        end
    end

    // Gated by rst_n so the combinational hold stays low while reset is held.
    assign accept   = rst_n && (|pending) && !bus.hold_pc && !bus.ex_jump_flag;
    assign vec_addr = VEC_BASE + ADDR_W'(id_q) * VEC_STRIDE;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        jump_flag = 1'b0;
        jump_pc   = '0;
        hold_flag = HoldNone;
        ack       = '0;
        active    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_flag = HoldPc;
                    epc_d     = bus.inst_addr;
                    id_d      = sel_id;
                    cnt_d     = 4'(DRAIN_CYCLES - 1);
                    state_d   = (DRAIN_CYCLES > 1) ? StDrain : StJump;
                end
            end
            StDrain: begin
                hold_flag = HoldPc;
                cnt_d     = cnt_q - 4'd1;
                // An older branch resolving now owns the PC; the ISR must return to it.
                if (bus.ex_jump_flag) begin
                    epc_d = bus.ex_jump_pc;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = StJump;
                end
            end
            StJump: begin
                jump_flag   = 1'b1;
                jump_pc     = vec_addr;
                hold_flag   = HoldPpl;
                ack[id_q]   = 1'b1;
                state_d     = StService;
            end
            StService: begin
                active = 1'b1;
                if (bus.reti) begin
                    state_d = StReturn;
                end
            end
            StReturn: begin
                jump_flag = 1'b1;
                jump_pc   = epc_q;
                hold_flag = HoldPpl;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            cnt_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.int_jump_flag = jump_flag;
    assign bus.int_jump_pc   = jump_pc;
    assign bus.int_hold_flag = hold_flag;
    assign bus.irq_ack       = ack;
    assign bus.epc           = epc_q;
    assign bus.int_active    = active;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: entry latency, priority/mask, branch interaction,
// return, reti filtering, no-nesting and asynchronous reset.
module tb_int_ctrl;

    logic clk;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    int_ctrl_if #(.ADDR_W(16), .NUM_IRQ(4)) bus ();

    int_ctrl #(
        .ADDR_W      (16),
        .NUM_IRQ     (4),
        .VEC_BASE    (16'h0040),
        .VEC_STRIDE  (16'h0004),
        .DRAIN_CYCLES(3)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {jump, jump_pc, hold, ack, active}
    wire [23:0] obs = {bus.int_jump_flag, bus.int_jump_pc, bus.int_hold_flag,
                       bus.irq_ack, bus.int_active};

    function automatic logic [23:0] st(input logic j, input logic [15:0] pc,
                                       input logic [1:0] h, input logic [3:0] a,
                                       input logic act);
        return {j, pc, h, a, act};
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    // Drives a return from SERVICE; leaves the bench 1 ns into the first IDLE cycle.
    task automatic finish_isr();
        bus.reti = 1'b1;
        next_cyc();
        bus.reti = 1'b0;
        next_cyc();
    endtask

    task automatic test_reset();
        logic [23:0] e;
        next_cyc();
        mid();
        e = st(0, 16'h0, 2'b00, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want %h", obs, e);
        end
        tests_run++;
        if (bus.epc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_epc: got %h want 0000", bus.epc);
        end
        next_cyc();
        bus.irq    = 4'b0001;
        bus.irq_en = 4'hF;
        mid();
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reset_irq_held: got %h want %h", obs, e);
        end
        bus.irq = 4'h0;
        next_cyc();
        rst_n = 1'b1;
        mid();
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reset_release: got %h want %h", obs, e);
        end
    endtask

    task automatic test_basic();
        logic [23:0] e;
        next_cyc();
        bus.irq       = 4'b0100;
        bus.irq_en    = 4'hF;
        bus.inst_addr = 16'h0012;
        mid();
        for (int c = 0; c < 3; c++) begin
            e = st(0, 16'h0, 2'b01, 4'h0, 0);
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL basic_hold_T%0d: got %h want %h", c, obs, e);
            end
            next_cyc();
            bus.irq = 4'h0;
            mid();
        end
        e = st(1, 16'h0048, 2'b10, 4'b0100, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL basic_jump: got %h want %h", obs, e);
        end
        next_cyc();
        mid();
        e = st(0, 16'h0, 2'b00, 4'h0, 1);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL basic_service: got %h want %h", obs, e);
        end
        tests_run++;
        if (bus.epc !== 16'h0012) begin
            tests_failed++;
            $display("FAIL basic_epc: got %h want 0012", bus.epc);
        end
        next_cyc();
        bus.reti = 1'b1;
        mid();
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL basic_reti_cycle: got %h want %h", obs, e);
        end
        next_cyc();
        bus.reti = 1'b0;
        mid();
        e = st(1, 16'h0012, 2'b10, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL basic_return: got %h want %h", obs, e);
        end
        next_cyc();
        mid();
        e = st(0, 16'h0, 2'b00, 4'h0, 0);
        tests_run++;
        if (obs !== e || bus.epc !== 16'h0012) begin
            tests_failed++;
            $display("FAIL basic_idle: got %h epc %h want %h epc 0012", obs, bus.epc, e);
        end
        next_cyc();
    endtask

    task automatic test_priority();
        logic [23:0] e;
        bus.irq       = 4'b1011;
        bus.irq_en    = 4'b1110;
        bus.inst_addr = 16'h0100;
        mid();
        e = st(0, 16'h0, 2'b01, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL prio_accept: got %h want %h", obs, e);
        end
        next_cyc();
        next_cyc();
        next_cyc();
        mid();
        e = st(1, 16'h0044, 2'b10, 4'b0010, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL prio_jump: got %h want %h", obs, e);
        end
        bus.irq = 4'h0;
        next_cyc();
        mid();
        tests_run++;
        if (bus.epc !== 16'h0100 || bus.int_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_service: got epc %h active %b want 0100 1",
                     bus.epc, bus.int_active);
        end
        next_cyc();
        finish_isr();
        bus.irq_en = 4'hF;
    endtask

    task automatic test_branch();
        logic [23:0] e;
        bus.irq       = 4'b0001;
        bus.hold_pc   = 1'b1;
        bus.inst_addr = 16'h0020;
        mid();
        e = st(0, 16'h0, 2'b00, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL branch_hold_pc_blocks: got %h want %h", obs, e);
        end
        next_cyc();
        bus.hold_pc      = 1'b0;
        bus.ex_jump_flag = 1'b1;
        bus.ex_jump_pc   = 16'h0090;
        mid();
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL branch_ex_jump_blocks: got %h want %h", obs, e);
        end
        next_cyc();
        bus.ex_jump_flag = 1'b0;
        mid();
        e = st(0, 16'h0, 2'b01, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL branch_accept: got %h want %h", obs, e);
        end
        next_cyc();
        bus.ex_jump_flag = 1'b1;
        bus.ex_jump_pc   = 16'h0030;
        next_cyc();
        bus.ex_jump_flag = 1'b0;
        bus.irq          = 4'h0;
        next_cyc();
        mid();
        e = st(1, 16'h0040, 2'b10, 4'b0001, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL branch_jump: got %h want %h", obs, e);
        end
        next_cyc();
        mid();
        tests_run++;
        if (bus.epc !== 16'h0030) begin
            tests_failed++;
            $display("FAIL branch_epc: got %h want 0030", bus.epc);
        end
        next_cyc();
        bus.reti = 1'b1;
        next_cyc();
        bus.reti = 1'b0;
        mid();
        e = st(1, 16'h0030, 2'b10, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL branch_return: got %h want %h", obs, e);
        end
        next_cyc();
    endtask

    task automatic test_reti_ignored();
        logic [23:0] e;
        bus.reti = 1'b1;
        next_cyc();
        bus.reti = 1'b0;
        mid();
        e = st(0, 16'h0, 2'b00, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reti_idle: got %h want %h", obs, e);
        end
        next_cyc();
        bus.irq       = 4'b0100;
        bus.inst_addr = 16'h0050;
        next_cyc();
        bus.irq  = 4'h0;
        bus.reti = 1'b1;
        next_cyc();
        bus.reti = 1'b0;
        mid();
        e = st(0, 16'h0, 2'b01, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reti_drain: got %h want %h", obs, e);
        end
        next_cyc();
        mid();
        e = st(1, 16'h0048, 2'b10, 4'b0100, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL reti_drain_jump: got %h want %h", obs, e);
        end
        next_cyc();
        mid();
        tests_run++;
        if (bus.epc !== 16'h0050) begin
            tests_failed++;
            $display("FAIL reti_epc: got %h want 0050", bus.epc);
        end
        next_cyc();
        finish_isr();
    endtask

    task automatic test_no_nesting();
        logic [23:0] e;
        bus.irq       = 4'b0100;
        bus.inst_addr = 16'h0060;
        next_cyc();
        bus.irq = 4'h0;
        next_cyc();
        next_cyc();
        next_cyc();
        bus.irq = 4'b0001;
        mid();
        e = st(0, 16'h0, 2'b00, 4'h0, 1);
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL nest_service_%0d: got %h want %h", c, obs, e);
            end
            next_cyc();
            mid();
        end
        bus.reti = 1'b1;
        next_cyc();
        bus.reti      = 1'b0;
        bus.inst_addr = 16'h0070;
        mid();
        e = st(1, 16'h0060, 2'b10, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL nest_return: got %h want %h", obs, e);
        end
        next_cyc();
        mid();
        e = st(0, 16'h0, 2'b01, 4'h0, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL nest_accept_after_return: got %h want %h", obs, e);
        end
        next_cyc();
        bus.irq = 4'h0;
        next_cyc();
        next_cyc();
        mid();
        e = st(1, 16'h0040, 2'b10, 4'b0001, 0);
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL nest_jump_irq0: got %h want %h", obs, e);
        end
        next_cyc();
        next_cyc();
        finish_isr();
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        bus.irq       = 4'b0010;
        bus.inst_addr = 16'h0080;
        next_cyc();
        #2;
        rst_n = 1'b0;
        #1;
        e = st(0, 16'h0, 2'b00, 4'h0, 0);
        tests_run++;
        if (obs !== e || bus.epc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_async: got %h epc %h want %h epc 0000", obs, bus.epc, e);
        end
        bus.irq = 4'h0;
        next_cyc();
        rst_n = 1'b1;
        mid();
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL rstmid_quiet_%0d: got %h want %h", c, obs, e);
            end
            next_cyc();
            mid();
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.irq          = '0;
        bus.irq_en       = '0;
        bus.inst_addr    = '0;
        bus.hold_pc      = 1'b0;
        bus.ex_jump_flag = 1'b0;
        bus.ex_jump_pc   = '0;
        bus.reti         = 1'b0;
        test_reset();
        next_cyc();
        test_basic();
        test_priority();
        test_branch();
        test_reti_ignored();
        test_no_nesting();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1);
    end

endmodule
